// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single host commands into write32/read32/read64 transactions,
// with a per-phase watchdog so an unresponsive slave cannot stall the host.
module axi_lite_cmd_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,
  output logic                            rsp_valid,
  output logic [63:0]                     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned TimerW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerMax =
      TimerW'((C_TIMEOUT_CYCLES == 0) ? 0 : C_TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] AddrMask = ~AW'(3);

  typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                second_q, second_d;
  logic [AW-1:0]       awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW/8-1:0]     wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                timeout_q, timeout_d;
  logic                cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                expire, abort;

  assign expire = (C_TIMEOUT_CYCLES != 0) && (timer_q == TimerMax);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    second_d    = second_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q + TimerW'(1);
    abort       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d      = cmd_op;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          second_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = 2'b00;
          timeout_d = 1'b0;
          timer_d   = '0;
          case (cmd_op)
            2'd0: begin
              state_d   = StWrAwW;
              awaddr_d  = cmd_addr & AddrMask;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
            2'd1, 2'd2: begin
              state_d   = StRdAr;
              araddr_d  = cmd_addr & AddrMask;
              arvalid_d = 1'b1;
            end
            default: begin
              state_d = StDone;
              resp_d  = 2'b10;
            end
          endcase
        end
      end
      StWrAwW: begin
        // AW and W complete independently; move on once both have handshaken.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = StWrB;
          bready_d = 1'b1;
          timer_d  = '0;
        end else begin
          abort = expire;
        end
      end
      StWrB: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP > resp_q) resp_d = M_AXI_BRESP;
          state_d  = StDone;
        end else begin
          abort = expire;
        end
      end
      StRdAr: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
          timer_d   = '0;
        end else begin
          abort = expire;
        end
      end
      StRdR: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP > resp_q) resp_d = M_AXI_RRESP;
          if (op_q == 2'd2 && !second_q) begin
            rdata_d[63:32] = M_AXI_RDATA;
            second_d       = 1'b1;
            araddr_d       = araddr_q + AW'(4);
            arvalid_d      = 1'b1;
            state_d        = StRdAr;
            timer_d        = '0;
          end else begin
            rdata_d[31:0] = M_AXI_RDATA;
            state_d       = StDone;
          end
        end else begin
          abort = expire;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      resp_d    = 2'b10;
      timeout_d = 1'b1;
      state_d   = StDone;
    end

    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      second_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      second_q    <= second_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign busy          = (state_q != StIdle);
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a small AXI4-Lite slave model plus a response
// scoreboard of expected {timeout, resp, rdata} entries.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_timeout, busy;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(12),
    .C_TIMEOUT_CYCLES  (16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int errors = 0;
  logic [66:0] exp_q[$];    // {timeout, resp, rdata}
  logic [33:0] rd_q[$];     // {rresp, rdata} the slave returns
  logic [11:0] exp_ar_q[$];

  int          aw_delay = 0;
  bit          ar_never = 1'b0;
  bit          r_hold = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [11:0] exp_awaddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model: acts on the falling edge; handshakes seen at the previous rising edge are
  // reconstructed from what was presented during that cycle.
  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got;
    int aw_vcnt, r_pending;
    logic [11:0] awaddr_c, araddr_c;
    logic [31:0] wdata_c;
    logic [3:0]  wstrb_c;
    logic [63:0] exp_a;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; aw_got = 0; w_got = 0;
    aw_vcnt = 0; r_pending = 0;
    awaddr_c = '0; araddr_c = '0; wdata_c = '0; wstrb_c = '0;
    awready = 1'b0; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; aw_got = 0; w_got = 0;
        aw_vcnt = 0; r_pending = 0; bvalid = 1'b0; rvalid = 1'b0;
      end else begin
        if (hs_aw) begin
          aw_hs++; aw_got = 1; aw_vcnt = 0;
          chk("awaddr", 64'(awaddr_c), 64'(exp_awaddr));
        end
        if (hs_w) begin
          w_hs++; w_got = 1;
          chk("wdata", 64'(wdata_c), 64'(exp_wdata));
          chk("wstrb", 64'(wstrb_c), 64'(exp_wstrb));
        end
        if (hs_b) begin b_hs++; bvalid = 1'b0; end
        if (hs_ar) begin
          ar_hs++; r_pending++;
          if (exp_ar_q.size() > 0) exp_a = 64'(exp_ar_q.pop_front());
          else exp_a = 64'hDEAD_BEEF_0000_0000;
          chk("araddr", 64'(araddr_c), exp_a);
        end
        if (hs_r) rvalid = 1'b0;
        aw_cyc += int'(awvalid); w_cyc += int'(wvalid); ar_cyc += int'(arvalid);
        if (awvalid) begin
          awready = (aw_delay == 0) || (aw_vcnt >= aw_delay);
          aw_vcnt++;
        end else begin
          awready = (aw_delay == 0);
        end
        arready = !ar_never;
        if (!bvalid && aw_got && w_got) begin
          bvalid = 1'b1; bresp = cfg_bresp; aw_got = 0; w_got = 0;
        end
        if (!rvalid && r_pending > 0 && !r_hold && rd_q.size() > 0) begin
          {rresp, rdata} = rd_q.pop_front();
          rvalid = 1'b1; r_pending--;
        end
        hs_aw = awvalid && awready; awaddr_c = awaddr;
        hs_w  = wvalid && wready;   wdata_c = wdata; wstrb_c = wstrb;
        hs_ar = arvalid && arready; araddr_c = araddr;
        hs_b  = bvalid && bready;
        hs_r  = rvalid && rready;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [63:0] e_rdata,
                       input logic [1:0] e_resp, input logic e_to);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    exp_q.push_back({e_to, e_resp, e_rdata});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts falling edges after the accept edge; the first one is 1.
  task automatic wait_rsp(input int exp_lat);
    int n;
    logic [66:0] e;
    n = 1;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("rsp_rdata", rsp_rdata, e[63:0]);
    chk("rsp_resp", 64'(rsp_resp), 64'(e[65:64]));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(e[66]));
    @(negedge clk);
    #1;
    chk("rsp_single_pulse", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid,
                               rsp_timeout, busy, rsp_resp}), 64'd0);
    chk({tag, "_addr"}, 64'({awaddr, araddr}), 64'd0);
    chk({tag, "_rdata"}, rsp_rdata, 64'd0);
  endtask

  initial begin
    int b_aw, b_w, b_b, b_ar, b_awc, b_wc, b_arc, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // write32, always-ready slave
    exp_awaddr = 12'h010; exp_wdata = 32'h0000_0001; exp_wstrb = 4'hF;
    b_aw = aw_hs; b_w = w_hs; b_b = b_hs;
    issue(2'd0, 12'h010, 32'h0000_0001, 4'hF, 64'h0, 2'b00, 1'b0);
    wait_rsp(3);
    chk("wr_aw_hs", 64'(aw_hs - b_aw), 64'd1);
    chk("wr_w_hs", 64'(w_hs - b_w), 64'd1);
    chk("wr_b_hs", 64'(b_hs - b_b), 64'd1);

    // read64 from 0x100
    rd_q.push_back({2'b00, 32'h0000_0001});
    rd_q.push_back({2'b00, 32'h2345_6789});
    exp_ar_q.push_back(12'h100); exp_ar_q.push_back(12'h104);
    b_ar = ar_hs;
    issue(2'd2, 12'h100, '0, '0, 64'h0000_0001_2345_6789, 2'b00, 1'b0);
    wait_rsp(5);
    chk("rd64_ar_hs", 64'(ar_hs - b_ar), 64'd2);

    // write with AWREADY held off 5 cycles, WREADY immediate
    aw_delay = 5;
    exp_awaddr = 12'h020; exp_wdata = 32'hDEAD_BEEF; exp_wstrb = 4'h3;
    b_awc = aw_cyc; b_wc = w_cyc; b_b = b_hs;
    issue(2'd0, 12'h020, 32'hDEAD_BEEF, 4'h3, 64'h0, 2'b00, 1'b0);
    wait_rsp(8);
    chk("slow_aw_cycles", 64'(aw_cyc - b_awc), 64'd6);
    chk("slow_w_cycles", 64'(w_cyc - b_wc), 64'd1);
    chk("slow_b_hs", 64'(b_hs - b_b), 64'd1);
    aw_delay = 0;

    // watchdog: ARREADY never comes
    ar_never = 1'b1;
    b_arc = ar_cyc; b_ar = ar_hs;
    issue(2'd1, 12'h040, '0, '0, 64'h0, 2'b10, 1'b1);
    wait_rsp(17);
    chk("to_ar_cycles", 64'(ar_cyc - b_arc), 64'd16);
    chk("to_ar_hs", 64'(ar_hs - b_ar), 64'd0);
    ar_never = 1'b0;

    // read64 wrapping at top of address space, SLVERR on the second word
    rd_q.push_back({2'b00, 32'hCAFE_0001});
    rd_q.push_back({2'b10, 32'hBEEF_0002});
    exp_ar_q.push_back(12'hFFC); exp_ar_q.push_back(12'h000);
    issue(2'd2, 12'hFFC, '0, '0, 64'hCAFE_0001_BEEF_0002, 2'b10, 1'b0);
    wait_rsp(5);

    // reserved op: no bus traffic
    b_awc = aw_cyc; b_wc = w_cyc; b_arc = ar_cyc;
    issue(2'd3, 12'h010, '0, '0, 64'h0, 2'b10, 1'b0);
    wait_rsp(1);
    chk("rsvd_no_valids", 64'((aw_cyc - b_awc) + (w_cyc - b_wc) + (ar_cyc - b_arc)), 64'd0);

    // misaligned write address is forced aligned; DECERR response
    cfg_bresp = 2'b11;
    exp_awaddr = 12'h020; exp_wdata = 32'h0BAD_F00D; exp_wstrb = 4'hC;
    issue(2'd0, 12'h023, 32'h0BAD_F00D, 4'hC, 64'h0, 2'b11, 1'b0);
    wait_rsp(3);
    cfg_bresp = 2'b00;

    // read32 places data in the low word
    rd_q.push_back({2'b00, 32'hA5A5_1234});
    exp_ar_q.push_back(12'h044);
    issue(2'd1, 12'h046, '0, '0, 64'h0000_0000_A5A5_1234, 2'b00, 1'b0);
    wait_rsp(3);

    // reset while waiting in the read-data phase
    r_hold = 1'b1;
    rd_q.push_back({2'b00, 32'h1111_2222});
    exp_ar_q.push_back(12'h080);
    issue(2'd1, 12'h080, '0, '0, 64'h0, 2'b00, 1'b0);
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    chk("mid_reset_in_rd_r", 64'(rready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete(); rd_q.delete(); exp_ar_q.delete();
    r_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rd_q.push_back({2'b00, 32'h1357_9BDF});
    exp_ar_q.push_back(12'h008);
    issue(2'd1, 12'h008, '0, '0, 64'h0000_0000_1357_9BDF, 2'b00, 1'b0);
    wait_rsp(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
